fft_power_peak: RTL and testbench

FFT_POWER_PEAK -- requirements
Module: fft_power_peak

---
 rtl/fft_power_peak_pkg.sv | 11 +
 rtl/fft_cmag_sq.sv | 84 ++++++++
 rtl/fft_power_peak.sv | 124 ++++++++++++
 tb/tb_fft_power_peak.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_power_peak_pkg.sv
// Shared FFT definitions: default widths, pipeline depth and the framing FSM encoding.
package fft_power_peak_pkg;

  localparam int IWIDTH_DEF  = 22;
  localparam int LGSIZE_DEF  = 11;
  localparam int PIPE_STAGES = 3;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/fft_cmag_sq.sv
// Three-stage |x|^2 pipeline (register, two squares, sum) with a side tag, advanced on ce.
module fft_cmag_sq
  import fft_power_peak_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int TAG_W  = LGSIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  i_valid,
  input  logic [2*IWIDTH-1:0]   i_sample,
  input  logic [TAG_W-1:0]      i_tag,
  output logic                  o_valid,
  output logic [2*IWIDTH-1:0]   o_power,
  output logic [TAG_W-1:0]      o_tag
);

  localparam int SQW = 2*IWIDTH-1;
  localparam int PW  = 2*IWIDTH;

  logic [PIPE_STAGES:1]      vld_pipe_q, vld_pipe_d;
  logic signed [IWIDTH-1:0]  re_q, re_d, im_q, im_d;
  logic [SQW-1:0]            sq_re_q, sq_re_d, sq_im_q, sq_im_d;
  logic [PW-1:0]             pow_q, pow_d;
  logic [TAG_W-1:0]          tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [IWIDTH-1:0]         mag_re, mag_im;

  always_comb begin
    // Squaring the magnitude keeps -2^(IWIDTH-1) exact: its negation wraps to 2^(IWIDTH-1) unsigned.
    mag_re     = re_q[IWIDTH-1] ? IWIDTH'(-re_q) : IWIDTH'(re_q);
    mag_im     = im_q[IWIDTH-1] ? IWIDTH'(-im_q) : IWIDTH'(im_q);
    vld_pipe_d = vld_pipe_q;
    re_d       = re_q;
    im_d       = im_q;
    sq_re_d    = sq_re_q;
    sq_im_d    = sq_im_q;
    pow_d      = pow_q;
    tag1_d     = tag1_q;
    tag2_d     = tag2_q;
    tag3_d     = tag3_q;
    if (ce) begin
      vld_pipe_d = {vld_pipe_q[PIPE_STAGES-1:1], i_valid};
      re_d       = i_sample[PW-1:IWIDTH];
      im_d       = i_sample[IWIDTH-1:0];
      sq_re_d    = SQW'(mag_re) * SQW'(mag_re);
      sq_im_d    = SQW'(mag_im) * SQW'(mag_im);
      pow_d      = PW'(sq_re_q) + PW'(sq_im_q);
      tag1_d     = i_tag;
      tag2_d     = tag1_q;
      tag3_d     = tag2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      re_q       <= '0;
      im_q       <= '0;
      sq_re_q    <= '0;
      sq_im_q    <= '0;
      pow_q      <= '0;
      tag1_q     <= '0;
      tag2_q     <= '0;
      tag3_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      re_q       <= re_d;
      im_q       <= im_d;
      sq_re_q    <= sq_re_d;
      sq_im_q    <= sq_im_d;
      pow_q      <= pow_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      tag3_q     <= tag3_d;
    end
  end

  // Output only counts on enabled cycles, so a gapped stream never shows a stale result twice.
  assign o_valid = vld_pipe_q[PIPE_STAGES] & ce;
  assign o_power = pow_q;
  assign o_tag   = tag3_q;

endmodule

// File: rtl/fft_power_peak.sv
// FFT bin power with per-frame peak search; frames are aligned to i_sync and tracked by a bin counter.
module fft_power_peak
  import fft_power_peak_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int LGSIZE = LGSIZE_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic                 i_sync,
  input  logic [2*IWIDTH-1:0]  i_result,
  output logic [2*IWIDTH-1:0]  o_power,
  output logic                 o_valid,
  output logic                 o_sync,
  output logic [LGSIZE-1:0]    o_bin,
  output logic [2*IWIDTH-1:0]  o_peak_power,
  output logic [LGSIZE-1:0]    o_peak_bin,
  output logic                 o_peak_valid
);

  localparam int               PW       = 2*IWIDTH;
  localparam logic [LGSIZE-1:0] LAST_BIN = '1;

  logic [0:0]        state_q, state_d;
  logic [LGSIZE-1:0] cnt_q, cnt_d;
  logic              in_vld;
  logic [LGSIZE-1:0] in_bin;

  logic              pipe_vld;
  logic [PW-1:0]     pipe_pow;
  logic [LGSIZE-1:0] pipe_bin;

  logic [PW-1:0]     run_pow_q, run_pow_d, pk_pow_q, pk_pow_d, cand_pow;
  logic [LGSIZE-1:0] run_bin_q, run_bin_d, pk_bin_q, pk_bin_d, cand_bin;
  logic              pk_vld_q, pk_vld_d;

  // cnt_q is the bin the next accepted sample gets; any sync forces bin 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_vld  = 1'b0;
    in_bin  = cnt_q;
    if (i_ce) begin
      if (i_sync) begin
        state_d = ST_RUN;
        in_vld  = 1'b1;
        in_bin  = '0;
        cnt_d   = LGSIZE'(1);
      end else if (state_q == ST_RUN) begin
        in_vld  = 1'b1;
        cnt_d   = cnt_q + LGSIZE'(1);
      end
    end
  end

  fft_cmag_sq #(
    .IWIDTH (IWIDTH),
    .TAG_W  (LGSIZE)
  ) u_cmag_sq (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .ce       (i_ce),
    .i_valid  (in_vld),
    .i_sample (i_result),
    .i_tag    (in_bin),
    .o_valid  (pipe_vld),
    .o_power  (pipe_pow),
    .o_tag    (pipe_bin)
  );

  // Bin 0 reloads the running peak, which also drops whatever a truncated frame had collected.
  always_comb begin
    run_pow_d = run_pow_q;
    run_bin_d = run_bin_q;
    pk_pow_d  = pk_pow_q;
    pk_bin_d  = pk_bin_q;
    pk_vld_d  = 1'b0;
    cand_pow  = run_pow_q;
    cand_bin  = run_bin_q;
    if (pipe_vld) begin
      if (pipe_bin == '0 || pipe_pow > run_pow_q) begin
        cand_pow = pipe_pow;
        cand_bin = pipe_bin;
      end
      run_pow_d = cand_pow;
      run_bin_d = cand_bin;
      if (pipe_bin == LAST_BIN) begin
        pk_pow_d = cand_pow;
        pk_bin_d = cand_bin;
        pk_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_WAIT;
      cnt_q     <= '0;
      run_pow_q <= '0;
      run_bin_q <= '0;
      pk_pow_q  <= '0;
      pk_bin_q  <= '0;
      pk_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_pow_q <= run_pow_d;
      run_bin_q <= run_bin_d;
      pk_pow_q  <= pk_pow_d;
      pk_bin_q  <= pk_bin_d;
      pk_vld_q  <= pk_vld_d;
    end
  end

  assign o_valid      = pipe_vld;
  assign o_power      = pipe_pow;
  assign o_bin        = pipe_bin;
  assign o_sync       = pipe_vld && (pipe_bin == '0);
  assign o_peak_power = pk_pow_q;
  assign o_peak_bin   = pk_bin_q;
  assign o_peak_valid = pk_vld_q;

endmodule

// File: tb/tb_fft_power_peak.sv
// Directed bench for fft_power_peak: frame-level model with output and peak scoreboards.
module tb_fft_power_peak;

  localparam int IW = 22;
  localparam int LG = 11;
  localparam int N  = 2048;
  localparam int PW = 2*IW;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_ce = 1'b0;
  logic          i_sync = 1'b0;
  logic [PW-1:0] i_result = '0;
  logic [PW-1:0] o_power, o_peak_power;
  logic          o_valid, o_sync, o_peak_valid;
  logic [LG-1:0] o_bin, o_peak_bin;

  fft_power_peak #(.IWIDTH(IW), .LGSIZE(LG)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_ce         (i_ce),
    .i_sync       (i_sync),
    .i_result     (i_result),
    .o_power      (o_power),
    .o_valid      (o_valid),
    .o_sync       (o_sync),
    .o_bin        (o_bin),
    .o_peak_power (o_peak_power),
    .o_peak_bin   (o_peak_bin),
    .o_peak_valid (o_peak_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [PW-1:0] pow;
    int            bin;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  exp_t eq[$];
  exp_t pq[$];

  // Frame model: waits for the first sync, numbers samples, and scans each full frame for its peak.
  bit     waiting = 1'b1;
  int     nextb = 0;
  longint fp[N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint pw(input int re, input int im);
    return longint'(re) * re + longint'(im) * im;
  endfunction

  task automatic model_accept(input bit sync, input int re, input int im);
    int     b;
    int     bb;
    longint best;
    if (waiting && !sync) return;
    waiting = 1'b0;
    b = sync ? 0 : nextb;
    eq.push_back('{pow: PW'(pw(re, im)), bin: b});
    fp[b] = pw(re, im);
    nextb = (b + 1) % N;
    if (b == N-1) begin
      best = fp[0];
      bb   = 0;
      for (int i = 1; i < N; i++)
        if (fp[i] > best) begin
          best = fp[i];
          bb   = i;
        end
      pq.push_back('{pow: PW'(best), bin: bb});
    end
  endtask

  task automatic drive(input bit ce, input bit sync, input int re, input int im);
    @(posedge i_clk);
    #1;
    i_ce     = ce;
    i_sync   = sync;
    i_result = {IW'(re), IW'(im)};
    if (ce) model_accept(sync, re, im);
  endtask

  task automatic flush();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_o_valid"},      o_valid, 0);
    chk({tag, "_o_sync"},       o_sync, 0);
    chk({tag, "_o_peak_valid"}, o_peak_valid, 0);
    chk({tag, "_o_power"},      o_power, 0);
    chk({tag, "_o_bin"},        o_bin, 0);
    chk({tag, "_o_peak_power"}, o_peak_power, 0);
    chk({tag, "_o_peak_bin"},   o_peak_bin, 0);
  endtask

  // Compare process: every enabled output against the model, peaks against the frame scan.
  exp_t          ce_e;
  logic [PW-1:0] last_pk_pow = '0;
  int            last_pk_bin = 0;

  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      last_pk_pow = '0;
      last_pk_bin = 0;
    end else begin
      if (!i_ce) chk("valid_without_ce", o_valid, 0);
      if (o_valid) begin
        if (eq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: o_bin=%0d o_power=%0d with no sample pending", o_bin, o_power);
        end else begin
          ce_e = eq.pop_front();
          chk("power", o_power, ce_e.pow);
          chk("bin",   o_bin,   ce_e.bin);
          chk("sync",  o_sync,  longint'(ce_e.bin == 0));
        end
      end
      if (o_peak_valid) begin
        strobes++;
        if (pq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_peak: o_peak_bin=%0d o_peak_power=%0d with no frame completed", o_peak_bin, o_peak_power);
        end else begin
          ce_e = pq.pop_front();
          chk("peak_power", o_peak_power, ce_e.pow);
          chk("peak_bin",   o_peak_bin,   ce_e.bin);
          last_pk_pow = ce_e.pow;
          last_pk_bin = ce_e.bin;
        end
      end else begin
        chk("peak_power_hold", o_peak_power, last_pk_pow);
        chk("peak_bin_hold",   o_peak_bin,   last_pk_bin);
      end
    end
  end

  int s0;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Latency and full-scale width: bin0 {3,4}, bin1 {-2^21,-2^21}
    drive(1, 1, 3, 4);
    drive(1, 0, -2097152, -2097152);
    drive(1, 0, 0, 0);
    chk("latency_not_yet", o_valid, 0);
    drive(1, 0, 0, 0);
    chk("latency_valid", o_valid, 1);
    chk("latency_sync",  o_sync, 1);
    chk("latency_power", o_power, 25);
    chk("latency_bin",   o_bin, 0);
    drive(1, 0, 0, 0);
    chk("extreme_power", o_power, 64'd8796093022208);
    chk("extreme_bin",   o_bin, 1);
    for (int b = 5; b < N; b++) drive(1, 0, 0, 0);
    flush();
    chk("frame1_peak_power", o_peak_power, 64'd8796093022208);
    chk("frame1_peak_bin",   o_peak_bin, 1);

    // Ties: bins 5 and 900 both 100
    s0 = strobes;
    drive(1, 1, 0, 0);
    for (int b = 1; b < N; b++)
      if (b == 5)        drive(1, 0, 10, 0);
      else if (b == 900) drive(1, 0, -6, 8);
      else               drive(1, 0, 0, 0);
    flush();
    chk("tie_strobes",    strobes - s0, 1);
    chk("tie_peak_power", o_peak_power, 100);
    chk("tie_peak_bin",   o_peak_bin, 5);

    // All-zero frame
    for (int b = 0; b < N; b++) drive(1, b == 0, 0, 0);
    flush();
    chk("zero_peak_power", o_peak_power, 0);
    chk("zero_peak_bin",   o_peak_bin, 0);

    // Gapped clock enable over a whole frame
    for (int b = 0; b < N; b++) begin
      drive(1, b == 0, (b % 97) - 48, ((b * 7) % 51) - 25);
      drive(0, 0, 0, 0);
    end
    flush();

    // Early sync at bin 1000 discards a frame holding a larger value at bin 10
    s0 = strobes;
    drive(1, 1, 0, 0);
    for (int b = 1; b < 1000; b++) drive(1, 0, (b == 10) ? 1000 : 1, 0);
    for (int b = 0; b < N; b++) drive(1, b == 0, (b == 77) ? -300 : 1, (b == 77) ? 400 : 0);
    flush();
    chk("early_strobes",    strobes - s0, 1);
    chk("early_peak_power", o_peak_power, 250000);
    chk("early_peak_bin",   o_peak_bin, 77);

    // Reset at bin 500, then unsynced samples must be ignored
    drive(1, 1, 0, 0);
    for (int b = 1; b < 500; b++) drive(1, 0, (b == 123) ? 2000 : 1, (b == 123) ? 2000 : 1);
    drive(1, 0, 1, 1);
    @(posedge i_clk);
    #3;
    i_reset_n = 1'b0;
    eq.delete();
    pq.delete();
    waiting = 1'b1;
    nextb   = 0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int i = 0; i < 50; i++) drive(1, 0, 500, 500);
    chk("no_valid_after_reset", o_valid, 0);
    for (int b = 0; b < N; b++) drive(1, b == 0, (b == N-1) ? 5 : 1, (b == N-1) ? 5 : 1);
    flush();
    chk("last_bin_peak_power", o_peak_power, 50);
    chk("last_bin_peak_bin",   o_peak_bin, N-1);

    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("pending_samples", eq.size(), 3);
    chk("pending_peaks",   pq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
